// File: rtl/mac_feeder_pkg.sv
// Shared constants for mac_feeder and the mul_add unit it drives: opcodes on
// both sides, FSM state encoding, STATUS word layout and the FIFO entry type.
package mac_feeder_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int N_WIDTH    = 5;
  localparam int TIMEOUT    = 64;
  localparam int WDOG_WIDTH = $clog2(TIMEOUT + 1);

  // Opcodes seen by the CPU on the feeder's own custom instruction
  localparam logic [N_WIDTH-1:0] FEED_CLEAR  = N_WIDTH'(0);
  localparam logic [N_WIDTH-1:0] FEED_PUSH   = N_WIDTH'(1);
  localparam logic [N_WIDTH-1:0] FEED_RUN    = N_WIDTH'(2);
  localparam logic [N_WIDTH-1:0] FEED_STATUS = N_WIDTH'(3);

  // Opcodes understood by mul_add
  localparam logic [N_WIDTH-1:0] MAC_CLEAR = N_WIDTH'(0);
  localparam logic [N_WIDTH-1:0] MAC_ADD   = N_WIDTH'(1);
  localparam logic [N_WIDTH-1:0] MAC_READ  = N_WIDTH'(2);

  localparam int STAT_OVF_BIT = 31;
  localparam int STAT_TMO_BIT = 30;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_ACK,
    ISSUE,
    WAIT_MAC,
    ACK
  } feed_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } pair_t;

  function automatic logic [DATA_WIDTH-1:0] statusWord(
    input logic                ovf,
    input logic                tmo,
    input logic [ADDR_WIDTH:0] count
  );
    logic [DATA_WIDTH-1:0] w;
    w                = '0;
    w[STAT_OVF_BIT]  = ovf;
    w[STAT_TMO_BIT]  = tmo;
    w[ADDR_WIDTH:0]  = count;
    return w;
  endfunction

endpackage

// File: rtl/mac_feeder_if.sv
// CPU custom-instruction port plus the mul_add port of mac_feeder; the feeder
// takes the slave view, the CPU/mul_add environment takes the master view.
interface mac_feeder_if;
  import mac_feeder_pkg::*;

  logic                  clk_en;
  logic                  start;
  logic [N_WIDTH-1:0]    n;
  logic [DATA_WIDTH-1:0] dataa;
  logic [DATA_WIDTH-1:0] datab;
  logic [DATA_WIDTH-1:0] result;
  logic                  done;

  logic                  mac_clk_en;
  logic                  mac_start;
  logic [N_WIDTH-1:0]    mac_n;
  logic [DATA_WIDTH-1:0] mac_dataa;
  logic [DATA_WIDTH-1:0] mac_datab;
  logic [DATA_WIDTH-1:0] mac_result;
  logic                  mac_done;

  modport master (
    output clk_en, start, n, dataa, datab, mac_result, mac_done,
    input  result, done, mac_clk_en, mac_start, mac_n, mac_dataa, mac_datab
  );

  modport slave (
    input  clk_en, start, n, dataa, datab, mac_result, mac_done,
    output result, done, mac_clk_en, mac_start, mac_n, mac_dataa, mac_datab
  );

endinterface

// File: rtl/mac_feeder_pair_fifo.sv
// Synchronous FIFO of operand pairs; flush empties it in one cycle and
// takes priority over a simultaneous write or read.
module pair_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             doWr;
  logic             doRd;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];

  assign doWr = wr_en_i && !full_o;
  assign doRd = rd_en_i && !empty_o;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two
      if (doWr) wrPtr_d = wrPtr_q + AW'(1);
      if (doRd) rdPtr_d = rdPtr_q + AW'(1);
      count_d = count_q + CW'(doWr) - CW'(doRd);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doWr && !flush_i) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/mac_feeder.sv
// Custom-instruction front end: queues (a, b) pairs from the CPU and, on RUN,
// streams them into mul_add as ADDs followed by a READ of the accumulator.
module mac_feeder
  import mac_feeder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  mac_feeder_if.slave bus
);

  feed_state_e           state_q, state_d;
  logic                  ovf_q, ovf_d;
  logic                  tmo_q, tmo_d;
  logic [WDOG_WIDTH-1:0] wdog_q, wdog_d;
  logic [DATA_WIDTH-1:0] ackData_q, ackData_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  done_q, done_d;
  logic                  macStart_q, macStart_d;
  logic                  macClkEn_q, macClkEn_d;
  logic [N_WIDTH-1:0]    macN_q, macN_d;
  logic [DATA_WIDTH-1:0] macA_q, macA_d;
  logic [DATA_WIDTH-1:0] macB_q, macB_d;

  logic                  accept;
  logic                  pickNext;
  logic                  fifoWr;
  logic                  fifoRd;
  logic                  fifoFlush;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic [ADDR_WIDTH:0]   fifoCount;
  pair_t                 fifoWrData;
  pair_t                 fifoHead;

  assign accept     = (state_q == IDLE) && bus.start && bus.clk_en;
  assign fifoWrData = {bus.dataa, bus.datab};

  pair_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (fifoFlush),
    .wr_en_i (fifoWr),
    .wdata_i (fifoWrData),
    .rd_en_i (fifoRd),
    .rdata_o (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  always_comb begin
    state_d   = state_q;
    ovf_d     = ovf_q;
    tmo_d     = tmo_q;
    wdog_d    = wdog_q;
    ackData_d = ackData_q;
    result_d  = result_q;
    done_d    = 1'b0;
    macN_d    = macN_q;
    macA_d    = macA_q;
    macB_d    = macB_q;
    fifoWr    = 1'b0;
    fifoRd    = 1'b0;
    fifoFlush = 1'b0;
    pickNext  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.n)
            FEED_CLEAR: begin
              fifoFlush = 1'b1;
              ovf_d     = 1'b0;
              tmo_d     = 1'b0;
              macN_d    = MAC_CLEAR;
              state_d   = ISSUE;
            end
            FEED_PUSH: begin
              if (fifoFull) ovf_d  = 1'b1;
              else          fifoWr = 1'b1;
              state_d = PUSH_ACK;
            end
            FEED_RUN: begin
              pickNext = 1'b1;
              state_d  = ISSUE;
            end
            // Unknown opcodes answer like STATUS so the CPU never stalls
            default: begin
              ackData_d = statusWord(ovf_q, tmo_q, fifoCount);
              state_d   = ACK;
            end
          endcase
        end
      end
      PUSH_ACK: begin
        done_d   = 1'b1;
        result_d = statusWord(ovf_q, tmo_q, fifoCount);
        state_d  = IDLE;
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT_MAC;
      end
      WAIT_MAC: begin
        if (bus.mac_done) begin
          if (macN_q == MAC_ADD) begin
            pickNext = 1'b1;
            state_d  = ISSUE;
          end else begin
            ackData_d = bus.mac_result;
            state_d   = ACK;
          end
        end else if (wdog_q == WDOG_WIDTH'(TIMEOUT - 1)) begin
          tmo_d     = 1'b1;
          fifoFlush = 1'b1;
          ackData_d = statusWord(ovf_q, 1'b1, '0);
          state_d   = ACK;
        end else begin
          wdog_d = wdog_q + WDOG_WIDTH'(1);
        end
      end
      ACK: begin
        done_d   = 1'b1;
        result_d = ackData_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Operands are latched on entry to ISSUE and then frozen until the op completes
    if (pickNext) begin
      if (!fifoEmpty) begin
        fifoRd = 1'b1;
        macN_d = MAC_ADD;
        macA_d = fifoHead.a;
        macB_d = fifoHead.b;
      end else begin
        macN_d = MAC_READ;
      end
    end
  end

  assign macStart_d = (state_d == ISSUE);
  assign macClkEn_d = (state_d == ISSUE) || (state_d == WAIT_MAC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
      wdog_q     <= '0;
      ackData_q  <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      macStart_q <= 1'b0;
      macClkEn_q <= 1'b0;
      macN_q     <= '0;
      macA_q     <= '0;
      macB_q     <= '0;
    end else begin
      state_q    <= state_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
      wdog_q     <= wdog_d;
      ackData_q  <= ackData_d;
      result_q   <= result_d;
      done_q     <= done_d;
      macStart_q <= macStart_d;
      macClkEn_q <= macClkEn_d;
      macN_q     <= macN_d;
      macA_q     <= macA_d;
      macB_q     <= macB_d;
    end
  end

  assign bus.result     = result_q;
  assign bus.done       = done_q;
  assign bus.mac_start  = macStart_q;
  assign bus.mac_clk_en = macClkEn_q;
  assign bus.mac_n      = macN_q;
  assign bus.mac_dataa  = macA_q;
  assign bus.mac_datab  = macB_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Self-checking bench for mac_feeder with a behavioural mul_add stub and a
// queue-based reference model of the feeder's FIFO, flags and accumulator.
module tb_mac_feeder;

  localparam logic [4:0] OP_CLEAR  = 5'd0;
  localparam logic [4:0] OP_PUSH   = 5'd1;
  localparam logic [4:0] OP_RUN    = 5'd2;
  localparam logic [4:0] OP_STATUS = 5'd3;
  localparam logic [4:0] MOP_CLEAR = 5'd0;
  localparam logic [4:0] MOP_ADD   = 5'd1;
  localparam logic [4:0] MOP_READ  = 5'd2;
  localparam int FIFO_DEPTH = 16;

  typedef struct {
    logic [4:0]  n;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  int unsigned modelA[$];
  int unsigned modelB[$];
  bit          modelOvf = 1'b0;
  bit          modelTmo = 1'b0;
  int unsigned modelAcc = 0;

  op_t opLog[$];
  bit  stubHang = 1'b0;

  mac_feeder_if bus();

  mac_feeder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Small non-negative integers are exactly representable, so the reference
  // works in integers and converts to IEEE-754 single only for comparison
  function automatic logic [31:0] intToFloat(input int unsigned v);
    int          e;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    e = 31;
    while (v[e] == 1'b0) e--;
    m = (v << (23 - e)) & 32'h007F_FFFF;
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic int unsigned floatToInt(input logic [31:0] f);
    int          e;
    logic [23:0] m;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 127;
    m = {1'b1, f[22:0]};
    return int'(m >> (23 - e));
  endfunction

  function automatic logic [31:0] expStatus();
    return (modelOvf ? 32'h8000_0000 : 32'h0) |
           (modelTmo ? 32'h4000_0000 : 32'h0) |
           32'(modelA.size());
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // mul_add stand-in: random completion latency, optional hang, checks that
  // the feeder keeps its request stable and never re-issues while busy
  initial begin : macStub
    logic        busy;
    int          waitCnt;
    op_t         cur;
    int unsigned stubAcc;
    busy           = 1'b0;
    waitCnt        = 0;
    stubAcc        = 0;
    cur            = '{n: 5'd0, a: 32'h0, b: 32'h0};
    bus.mac_done   = 1'b0;
    bus.mac_result = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus.mac_done = 1'b0;
      if (busy) begin
        checkOutput("no mac_start while busy", {31'b0, bus.mac_start}, 32'h0);
        if (!bus.mac_clk_en && !stubHang) begin
          busy = 1'b0;
        end else if (!stubHang) begin
          if (waitCnt > 0) begin
            waitCnt--;
          end else begin
            checkOutput("mac_n held", 32'(bus.mac_n), 32'(cur.n));
            checkOutput("mac_dataa held", bus.mac_dataa, cur.a);
            checkOutput("mac_datab held", bus.mac_datab, cur.b);
            case (cur.n)
              MOP_CLEAR: begin
                bus.mac_result = intToFloat(stubAcc);
                stubAcc        = 0;
              end
              MOP_ADD: begin
                stubAcc        = stubAcc + floatToInt(cur.a) * floatToInt(cur.b);
                bus.mac_result = intToFloat(stubAcc);
              end
              default: bus.mac_result = intToFloat(stubAcc);
            endcase
            bus.mac_done = 1'b1;
            busy         = 1'b0;
          end
        end
      end else if (bus.mac_start && bus.mac_clk_en) begin
        cur = '{n: bus.mac_n, a: bus.mac_dataa, b: bus.mac_datab};
        opLog.push_back(cur);
        busy    = 1'b1;
        waitCnt = $urandom_range(0, 3);
      end
    end
  end

  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] res, output int lat);
    bit seen;
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.clk_en = 1'b1;
    bus.n      = op;
    bus.dataa  = a;
    bus.datab  = b;
    checkOutput("done low with start", {31'b0, bus.done}, 32'h0);
    seen = 1'b0;
    lat  = 0;
    res  = 'x;
    for (int k = 1; k <= 600 && !seen; k++) begin
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.clk_en = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
        lat  = k;
        res  = bus.result;
      end
    end
    checkOutput("done arrived", {31'b0, seen}, 32'h1);
    if (seen) begin
      @(posedge clk); #1;
      checkOutput("done single pulse", {31'b0, bus.done}, 32'h0);
    end
  endtask

  task automatic doPush(input int unsigned ai, input int unsigned bi, output logic [31:0] r);
    int lat;
    applyStimulus(OP_PUSH, intToFloat(ai), intToFloat(bi), r, lat);
    if (modelA.size() < FIFO_DEPTH) begin
      modelA.push_back(ai);
      modelB.push_back(bi);
    end else begin
      modelOvf = 1'b1;
    end
    checkOutput("PUSH status", r, expStatus());
    checkOutput("PUSH latency", 32'(lat), 32'd2);
  endtask

  task automatic doStatus(input string tag);
    logic [31:0] r;
    int          lat;
    applyStimulus(OP_STATUS, 32'h0, 32'h0, r, lat);
    checkOutput({tag, " result"}, r, expStatus());
    checkOutput({tag, " latency"}, 32'(lat), 32'd2);
  endtask

  task automatic doRun(input string tag, output logic [31:0] r);
    int          lat;
    int unsigned cnt;
    cnt = modelA.size();
    opLog.delete();
    applyStimulus(OP_RUN, 32'h0, 32'h0, r, lat);
    checkOutput({tag, " op count"}, 32'(opLog.size()), 32'(cnt + 1));
    for (int i = 0; i < int'(cnt) && i < opLog.size(); i++) begin
      checkOutput({tag, " ADD opcode"}, 32'(opLog[i].n), 32'(MOP_ADD));
      checkOutput({tag, " ADD a"}, opLog[i].a, intToFloat(modelA[i]));
      checkOutput({tag, " ADD b"}, opLog[i].b, intToFloat(modelB[i]));
    end
    if (opLog.size() > int'(cnt)) begin
      checkOutput({tag, " final READ"}, 32'(opLog[cnt].n), 32'(MOP_READ));
    end
    for (int i = 0; i < int'(cnt); i++) modelAcc += modelA[i] * modelB[i];
    modelA.delete();
    modelB.delete();
    checkOutput({tag, " result"}, r, intToFloat(modelAcc));
  endtask

  task automatic doClear(input string tag);
    logic [31:0] r;
    int          lat;
    opLog.delete();
    applyStimulus(OP_CLEAR, 32'h0, 32'h0, r, lat);
    checkOutput({tag, " op count"}, 32'(opLog.size()), 32'd1);
    if (opLog.size() > 0) checkOutput({tag, " mac opcode"}, 32'(opLog[0].n), 32'(MOP_CLEAR));
    checkOutput({tag, " result"}, r, intToFloat(modelAcc));
    modelAcc = 0;
    modelOvf = 1'b0;
    modelTmo = 1'b0;
    modelA.delete();
    modelB.delete();
  endtask

  initial begin : stimulus
    logic [31:0] r;
    int          lat;
    int unsigned k;
    bit          seenStart;
    bus.start  = 1'b0;
    bus.clk_en = 1'b0;
    bus.n      = 5'd0;
    bus.dataa  = 32'h0;
    bus.datab  = 32'h0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset result", bus.result, 32'h0);
    checkOutput("reset done", {31'b0, bus.done}, 32'h0);
    checkOutput("reset mac_start", {31'b0, bus.mac_start}, 32'h0);
    checkOutput("reset mac_clk_en", {31'b0, bus.mac_clk_en}, 32'h0);
    checkOutput("reset mac_n", 32'(bus.mac_n), 32'h0);
    checkOutput("reset mac_dataa", bus.mac_dataa, 32'h0);
    checkOutput("reset mac_datab", bus.mac_datab, 32'h0);
    rst_n = 1'b1;

    doStatus("reset STATUS");
    doClear("first CLEAR");

    doPush(2, 3, r);
    doPush(2, 3, r);
    doRun("two-pair RUN", r);
    checkOutput("two-pair RUN is 12.0", r, 32'h4140_0000);

    doClear("CLEAR after 12.0");
    doPush(2, 3, r);
    doRun("6.0 RUN", r);
    doRun("empty RUN", r);
    checkOutput("empty RUN is 6.0", r, 32'h40C0_0000);

    for (int round = 0; round < 4; round++) begin
      k = $urandom_range(0, 6);
      for (int i = 0; i < int'(k); i++) doPush($urandom_range(0, 15), $urandom_range(0, 15), r);
      doStatus("random STATUS");
      doRun("random RUN", r);
    end

    doClear("CLEAR before overflow");
    for (int i = 0; i < 17; i++) doPush($urandom_range(0, 15), $urandom_range(0, 15), r);
    checkOutput("17th PUSH status", r, 32'h8000_0010);
    doRun("full RUN", r);
    doStatus("sticky overflow STATUS");
    doClear("CLEAR after overflow");

    for (int i = 0; i < 3; i++) doPush($urandom_range(1, 15), $urandom_range(1, 15), r);
    stubHang = 1'b1;
    opLog.delete();
    applyStimulus(OP_RUN, 32'h0, 32'h0, r, lat);
    modelA.delete();
    modelB.delete();
    modelTmo = 1'b1;
    checkOutput("timeout result", r, 32'h4000_0000);
    checkOutput("timeout result model", r, expStatus());
    checkOutput("timeout mac_clk_en", {31'b0, bus.mac_clk_en}, 32'h0);
    checkOutput("timeout ops issued", 32'(opLog.size()), 32'd1);
    checkOutput("timeout latency window", {31'b0, (lat >= 66 && lat <= 68)}, 32'h1);
    stubHang = 1'b0;
    doStatus("post-timeout STATUS");
    doClear("CLEAR after timeout");

    doPush(4, 5, r);
    doPush(6, 7, r);
    stubHang = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.clk_en = 1'b1;
    bus.n      = OP_RUN;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.clk_en = 1'b0;
    seenStart  = 1'b0;
    for (int i = 0; i < 20 && !seenStart; i++) begin
      if (bus.mac_start) seenStart = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    checkOutput("mid-run mac_start seen", {31'b0, seenStart}, 32'h1);
    repeat (3) @(posedge clk);
    #3;
    checkOutput("mid-run mac_clk_en", {31'b0, bus.mac_clk_en}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort mac_start", {31'b0, bus.mac_start}, 32'h0);
    checkOutput("abort mac_clk_en", {31'b0, bus.mac_clk_en}, 32'h0);
    checkOutput("abort done", {31'b0, bus.done}, 32'h0);
    checkOutput("abort mac_dataa", bus.mac_dataa, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelA.delete();
    modelB.delete();
    modelOvf = 1'b0;
    modelTmo = 1'b0;
    stubHang = 1'b0;
    doStatus("post-abort STATUS");
    doClear("CLEAR after abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
